// File: rtl/thumb_decode_pipe.sv
// Thumb decode stage: pairs 32-bit prefix halfwords with their second halfword and
// presents one registered decode bundle per instruction under valid/ready flow control.
module thumb_decode_pipe #(
    parameter int IMM_W       = 32,
    parameter bit SUPPORT_T32 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_hw,
    input  logic             i_hw_valid,
    output logic             o_hw_ready,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [3:0]       o_op,
    output logic [3:0]       o_addrrn,
    output logic [3:0]       o_addrrt,
    output logic [3:0]       o_addrrd,
    output logic [IMM_W-1:0] o_imm,
    output logic [3:0]       o_cond,
    output logic             o_is32,
    output logic             o_undef
);
    typedef enum logic {S_IDLE, S_WAIT_HW2} state_t;

    state_t      state;
    logic [15:0] hw1;
    logic        accept, is_prefix, load;

    logic [3:0]       d_op, d_rn, d_rt, d_rd, d_cond;
    logic [IMM_W-1:0] d_imm;
    logic             d_is32, d_undef;

    logic signed [11:0] b_off;
    logic signed [8:0]  bc_off;
    logic signed [24:0] bl_off;

    assign o_hw_ready = rst & ~i_flush & (~o_valid | i_ready);
    assign accept     = i_hw_valid & o_hw_ready;
    assign is_prefix  = (SUPPORT_T32 != 1'b0) && (i_hw[15:13] == 3'b111) && (i_hw[12:11] != 2'b00);
    assign load       = accept & ((state == S_WAIT_HW2) | ~is_prefix);

    assign b_off  = {i_hw[10:0], 1'b0};
    assign bc_off = {i_hw[7:0], 1'b0};
    // BL offset: S:I1:I2:imm10:imm11:0, with I1/I2 recovered from J1/J2 of hw2
    assign bl_off = {hw1[10], ~(i_hw[13] ^ hw1[10]), ~(i_hw[11] ^ hw1[10]),
                     hw1[9:0], i_hw[10:0], 1'b0};

    always_comb begin
        d_op    = 4'd0;
        d_rn    = 4'd0;
        d_rt    = 4'd0;
        d_rd    = 4'd0;
        d_imm   = '0;
        d_cond  = 4'b1110;
        d_is32  = 1'b0;
        d_undef = 1'b0;
        if (state == S_WAIT_HW2) begin
            d_is32 = 1'b1;
            if (hw1[15:11] == 5'b11110 && i_hw[15:14] == 2'b11 && i_hw[12]) begin
                d_op  = 4'd12;
                d_rn  = 4'd15;
                d_rd  = 4'd14;
                d_imm = IMM_W'(bl_off);
            end else begin
                d_undef = 1'b1;
            end
        end else if (i_hw[15:9] == 7'b0001110) begin
            d_op  = 4'd1;
            d_rn  = {1'b0, i_hw[5:3]};
            d_rd  = {1'b0, i_hw[2:0]};
            d_imm = IMM_W'(i_hw[8:6]);
        end else if (i_hw[15:11] == 5'b10101) begin
            d_op  = 4'd2;
            d_rn  = 4'd13;
            d_rd  = {1'b0, i_hw[10:8]};
            d_imm = IMM_W'({i_hw[7:0], 2'b00});
        end else if (i_hw[15:7] == 9'b101100001) begin
            d_op  = 4'd3;
            d_rn  = 4'd13;
            d_rd  = 4'd13;
            d_imm = IMM_W'({i_hw[6:0], 2'b00});
        end else if (i_hw[15:11] == 5'b00100) begin
            d_op  = 4'd4;
            d_rd  = {1'b0, i_hw[10:8]};
            d_imm = IMM_W'(i_hw[7:0]);
        end else if (i_hw[15:8] == 8'b01000110) begin
            d_op = 4'd5;
            d_rn = i_hw[6:3];
            d_rd = {i_hw[7], i_hw[2:0]};
        end else if (i_hw[15:11] == 5'b01101) begin
            d_op  = 4'd6;
            d_rn  = {1'b0, i_hw[5:3]};
            d_rd  = {1'b0, i_hw[2:0]};
            d_imm = IMM_W'({i_hw[10:6], 2'b00});
        end else if (i_hw[15:11] == 5'b01001) begin
            d_op  = 4'd7;
            d_rn  = 4'd15;
            d_rd  = {1'b0, i_hw[10:8]};
            d_imm = IMM_W'({i_hw[7:0], 2'b00});
        end else if (i_hw[15:11] == 5'b01100) begin
            d_op  = 4'd8;
            d_rn  = {1'b0, i_hw[5:3]};
            d_rt  = {1'b0, i_hw[2:0]};
            d_imm = IMM_W'({i_hw[10:6], 2'b00});
        end else if (i_hw[15:11] == 5'b00101) begin
            d_op  = 4'd11;
            d_rn  = {1'b0, i_hw[10:8]};
            d_imm = IMM_W'(i_hw[7:0]);
        end else if (i_hw[15:11] == 5'b11100) begin
            d_op  = 4'd9;
            d_rn  = 4'd15;
            d_rd  = 4'd15;
            d_imm = IMM_W'(b_off);
        end else if (i_hw[15:12] == 4'b1101 && i_hw[11:9] != 3'b111) begin
            d_op   = 4'd10;
            d_rn   = 4'd15;
            d_rd   = 4'd15;
            d_cond = i_hw[11:8];
            d_imm  = IMM_W'(bc_off);
        end else begin
            d_undef = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            hw1      <= 16'd0;
            o_valid  <= 1'b0;
            o_op     <= 4'd0;
            o_addrrn <= 4'd0;
            o_addrrt <= 4'd0;
            o_addrrd <= 4'd0;
            o_imm    <= '0;
            o_cond   <= 4'd0;
            o_is32   <= 1'b0;
            o_undef  <= 1'b0;
        end else if (i_flush) begin
            state   <= S_IDLE;
            hw1     <= 16'd0;
            o_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (state == S_IDLE && is_prefix) begin
                    hw1   <= i_hw;
                    state <= S_WAIT_HW2;
                end else begin
                    hw1   <= 16'd0;
                    state <= S_IDLE;
                end
            end
            if (load) begin
                o_valid  <= 1'b1;
                o_op     <= d_op;
                o_addrrn <= d_rn;
                o_addrrt <= d_rt;
                o_addrrd <= d_rd;
                o_imm    <= d_imm;
                o_cond   <= d_cond;
                o_is32   <= d_is32;
                o_undef  <= d_undef;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/thumb_decode_pipe.md
# thumb_decode_pipe

Parametrised, handshaked instruction decode stage for the Thumb core. It accepts a stream of 16-bit halfwords from fetch and assembles 32-bit Thumb-2 encodings from two halfwords. It decodes the supported instruction set plus BL, and presents one registered decode bundle per instruction to execute under valid/ready flow control. Compared with the current decoder, it adds:

- 32-bit instruction support
- condition-field output
- undefined-instruction flagging
- word-scaled offsets
- pipeline flush
- downstream backpressure

## Interface
- IMM_W, 32, width of o_imm; legal range 25..32 (BL offset is 25 bits signed, sign-extended to IMM_W).
- SUPPORT_T32, 1, when 0 every 32-bit prefix halfword decodes as a single undefined 16-bit instruction.
- clk  in  1  clock; one clock domain, all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- i_hw  in  16  instruction halfword from fetch.
- i_hw_valid  in  1  i_hw is valid.
- o_hw_ready  out  1  stage accepts i_hw this cycle.
- i_flush  in  1  synchronous flush (taken branch in execute).
- o_valid  out  1  decode bundle valid.
- i_ready  in  1  execute accepts the bundle.
- o_op  out  4  class: 0 none/undef, 1 ADD imm3, 2 ADD SP-imm, 3 SUB SP, 4 MOV imm, 5 MOV reg, 6 LDR imm, 7 LDR literal, 8 STR imm, 9 B, 10 B<c>, 11 CMP imm, 12 BL.
- o_addrrn, o_addrrt, o_addrrd  out  4 each  register addresses; unused field is 0.
- o_imm  out  IMM_W  zero- or sign-extended immediate.
- o_cond  out  4  condition; 4'b1110 for every op except B<c>.
- o_is32  out  1  bundle came from a 32-bit encoding.
- o_undef  out  1  encoding unsupported; o_op=0.

## Operation
- Accept: a halfword is taken when i_hw_valid & o_hw_ready.
- Ready: o_hw_ready = rst & !i_flush & (!o_valid | i_ready), i.e. one halfword per cycle at full throughput.
- FSM IDLE:
  - Accepted halfword with i_hw[15:11] in {11101, 11110, 11111} and SUPPORT_T32=1: store it in hw1, go to WAIT_HW2, no bundle.
  - Any other accepted halfword: 16-bit decode loaded into the output register.
- FSM WAIT_HW2: the accepted halfword is hw2. The 32-bit decode is loaded, o_is32=1, state returns to IDLE.
- Output register:
  - Loads on every accepted halfword that completes an instruction.
  - Holds all fields while o_valid & !i_ready.
  - o_valid clears on handshake when there is no new load.
- 16-bit decodes (ir = halfword; unlisted fields = 0):
  - ADD imm3 (ir[15:9]=0001110): rn=ir[5:3], rd=ir[2:0], imm=ir[8:6].
  - ADD SP-imm (10101): rn=13, rd=ir[10:8], imm=ir[7:0]<<2.
  - SUB SP (ir[15:7]=101100001): rn=13, rd=13, imm=ir[6:0]<<2.
  - MOV imm (00100): rd=ir[10:8], imm=ir[7:0].
  - MOV reg (ir[15:8]=01000110): rn=ir[6:3], rd={ir[7],ir[2:0]}.
  - LDR imm (01101): rn=ir[5:3], rd=ir[2:0], imm=ir[10:6]<<2.
  - LDR literal (01001): rn=15, rd=ir[10:8], imm=ir[7:0]<<2.
  - STR imm (01100): rn=ir[5:3], rt=ir[2:0], imm=ir[10:6]<<2.
  - CMP imm (00101): rn=ir[10:8], imm=ir[7:0].
  - B (11100): rn=15, rd=15, imm=SignExtend(ir[10:0]:0).
  - B<c> (1101): rn=15, rd=15, cond=ir[11:8], imm=SignExtend(ir[7:0]:0). cond 1110 or 1111 → undef.
- 32-bit BL:
  - Encoding: hw1[15:11]=11110 and hw2[15:14]=11, hw2[12]=1. Fields: S=hw1[10], I1=~(hw2[13]^S), I2=~(hw2[11]^S).
  - Result: imm=SignExtend(S:I1:I2:hw1[9:0]:hw2[10:0]:0), rn=15, rd=14.
  - Any other 32-bit pair: op=0, undef=1, is32=1.
- Any unmatched 16-bit halfword: op=0, undef=1.

## Timing
- Reset (rst low, asynchronous): o_valid=0, every bundle field=0, hw1=0, state=IDLE, o_hw_ready=0.
  - First acceptance is possible on the first clk edge after rst rises.
- Latency: bundle valid on the cycle after the accepting edge of the final halfword. A 32-bit instruction takes at least 2 accept cycles.
- Flush has top priority, on the edge where i_flush=1:
  - o_valid←0, state←IDLE, hw1 discarded.
  - No halfword is accepted that cycle.
  - A pending bundle is dropped even if i_ready=1.
- Backpressure in WAIT_HW2 stalls hw2 acceptance; hw1 is retained indefinitely.
- Simultaneous handshake and new load: the new bundle replaces the old one with o_valid staying 1 (no bubble).
- Reset mid-operation (WAIT_HW2 or valid output): returns to reset values immediately.

## Test plan
- 0x1C4A → next cycle o_valid=1, op=1, rn=1, rd=2, imm=1, is32=0, cond=0xE.
- BL pair 0xF000, 0xF802 on consecutive cycles → no bundle after the first halfword; after the second: op=12, rd=14, rn=15, imm=4, is32=1. Repeat with 0xF7FF, 0xFFFE → imm=0xFFFFFFFC.
- 0xD0FE → op=10, cond=0, imm=0xFFFFFFFC. 0xDE00 → op=0, undef=1. 0x6848 → op=6, rn=1, rd=0, imm=4.
- Backpressure: hold i_ready=0 after 0x2005 while fetch keeps i_hw_valid=1 → o_hw_ready=0 and bundle (op=4, rd=0, imm=5) stable for 5 cycles. Release → the next halfword is accepted that cycle with no bubble.
- Flush in WAIT_HW2: 0xF000, then i_flush=1 with 0x2005 presented → that halfword is not accepted. 0x2005 re-presented next cycle → op=4, is32=0.
- Reset pulse while WAIT_HW2 and o_valid=1 → all outputs 0 immediately; after release, 0x1C4A decodes as 16-bit.
